instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator computer. It owns the program counter and instruction register and runs a single-port memory handshake for fetch and load/store. It issues one-cycle write strobes and steady mux selects to the register file, accumulator and ALU. It replaces free-running decode, so every datapath write happens at a defined cycle.

## Interface
- PC_W, 8, program counter and memory address width
- RST_PC, 0, PC value loaded on reset
- clk  in  1  rising-edge clock, sole clock
- rst_n  in  1  synchronous, active-low reset
- run  in  1  level; sequencer leaves IDLE while high
- mem_req  out  1  memory request, held until mem_rdy
- mem_we  out  1  write qualifier for mem_req (store)
- mem_addr  out  PC_W  request address
- mem_rdy  in  1  one-cycle completion; read data valid the same cycle
- mem_rdata  in  8  read data
- alu_zero  in  1  ALU zero flag, sampled in EXEC of a branch
- pc  out  PC_W  current program counter
- ir  out  8  latched instruction; [7:5] opcode, [4:0] field
- cntr_alu  out  2  ALU operation select
- sel_alu_in  out  1  ALU result to register write port
- sel_acc_in  out  1  accumulator source: 0 register, 1 immediate
- lw  out  1  register write source is memory data
- reg_we, acc_we  out  1  one-cycle write strobes
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE -> FETCH when run=1.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On mem_rdy: ir<=mem_rdata, pc<=pc+1 (mod 2^PC_W), go to DECODE.
- DECODE: one cycle. Selects for ir[7:5] become valid and stay stable through the end of the instruction.
- EXEC, by opcode:
  - 000: acc_we=1, sel_acc_in=0.
  - 001: acc_we=1, sel_acc_in=1.
  - 010 / 011 / 101: reg_we=1, sel_alu_in=1, lw=0; cntr_alu = 00 / 01 / 11 respectively.
  - 100: cntr_alu=10. If alu_zero=1, pc<=pc+sext(ir[4:0]) using the already-incremented pc, wrapping mod 2^PC_W. No write strobe.
  - 110 / 111: no strobe; go to MEM.
- MEM:
  - mem_req=1, mem_addr={zeros, ir[4:0]}, mem_we=1 for 110 and 0 for 111.
  - On mem_rdy: 110 goes to next; 111 goes to WB.
- WB (111 only): reg_we=1, lw=1.
- Next: if run=1 go to FETCH, else IDLE. A current instruction always completes once fetched.
- Unused selects hold their prior value. Only strobes carry meaning outside their cycle.

## Timing
- Reset (rst_n=0 at an edge), from the next edge:
  - state=IDLE, pc=RST_PC, ir=0, cntr_alu=00.
  - All strobes, selects, mem_req, mem_we and busy are 0.
- Reset overrides any state, including mid-handshake. mem_req drops at the reset edge, and a late mem_rdy is ignored.
- reg_we and acc_we are registered, asserted for exactly one cycle, never simultaneously.
- mem_rdy is ignored whenever mem_req=0. mem_addr and mem_we are stable while mem_req=1.
- With zero-wait memory (mem_rdy in the first request cycle), cycles per instruction:
  - 3 for ALU, accumulator and branch opcodes.
  - 4 for store.
  - 5 for load.
- Each memory wait cycle adds one cycle.
- Branch offset range is -16..+15 relative to pc+1. Wrap: pc=0xFE, offset +5 gives 0x04.
- run falling mid-instruction has no effect until the instruction's last cycle.

## Test plan
- Reset during MEM of a store with mem_rdy pending -> next cycle mem_req=0, mem_we=0, pc=RST_PC, state IDLE; a late mem_rdy causes no transition.
- run=1, zero-wait memory returning 0x41 (opcode 010) -> reg_we high exactly in cycle 3, cntr_alu=00, sel_alu_in=1, pc incremented by 1.
- Instruction 0xE3 (load, field 3), memory data ready after 2 wait cycles in both FETCH and MEM -> MEM mem_addr=0x03, reg_we+lw in WB, total 9 cycles.
- Branch 0x9F (offset -1) at pc=0x10 with alu_zero=1 -> pc=0x10; with alu_zero=0 -> pc=0x11.
- Branch offset +5 fetched at pc=0xFD, alu_zero=1 -> pc=0x03 (wrap).
- run dropped during EXEC of an accumulator op -> acc_we still pulses once, then IDLE with busy=0 and no further mem_req.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator computer: owns pc and ir,
// drives the single-port memory handshake and issues registered datapath strobes/selects.
module instr_sequencer #(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            mem_req,
    output logic            mem_we,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_rdy,
    input  logic [7:0]      mem_rdata,
    input  logic            alu_zero,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      ir,
    output logic [1:0]      cntr_alu,
    output logic            sel_alu_in,
    output logic            sel_acc_in,
    output logic            lw,
    output logic            reg_we,
    output logic            acc_we,
    output logic            busy,
    output logic [2:0]      state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    state_t          state;
    logic [2:0]      op;
    logic [PC_W-1:0] br_target;
    logic            finish;
    logic [PC_W-1:0] fin_pc;

    // Handshake: a memory transfer completes on the edge where mem_req and mem_rdy are
    // both high; mem_addr/mem_we never change while mem_req is high.
    assign op        = ir[7:5];
    assign br_target = pc + {{(PC_W-5){ir[4]}}, ir[4:0]};
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Last cycle of the instruction and the pc the next fetch should use.
    always_comb begin
        finish = 1'b0;
        fin_pc = pc;
        case (state)
            EXEC: begin
                finish = (op != 3'b110) && (op != 3'b111);
                if (op == 3'b100 && alu_zero)
                    fin_pc = br_target;
            end
            MEM:     finish = mem_req && mem_rdy && (op == 3'b110);
            WB:      finish = 1'b1;
            default: finish = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RST_PC;
            ir         <= 8'h00;
            cntr_alu   <= 2'b00;
            sel_alu_in <= 1'b0;
            sel_acc_in <= 1'b0;
            lw         <= 1'b0;
            reg_we     <= 1'b0;
            acc_we     <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
        end else begin
            reg_we <= 1'b0;
            acc_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state    <= FETCH;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end
                end
                FETCH: begin
                    if (mem_req && mem_rdy) begin
                        ir      <= mem_rdata;
                        pc      <= pc + PC_W'(1);
                        mem_req <= 1'b0;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    // Selects settle here so they are stable for the rest of the instruction.
                    state <= EXEC;
                    case (op)
                        3'b000: begin acc_we <= 1'b1; sel_acc_in <= 1'b0; end
                        3'b001: begin acc_we <= 1'b1; sel_acc_in <= 1'b1; end
                        3'b010: begin reg_we <= 1'b1; sel_alu_in <= 1'b1; lw <= 1'b0; cntr_alu <= 2'b00; end
                        3'b011: begin reg_we <= 1'b1; sel_alu_in <= 1'b1; lw <= 1'b0; cntr_alu <= 2'b01; end
                        3'b101: begin reg_we <= 1'b1; sel_alu_in <= 1'b1; lw <= 1'b0; cntr_alu <= 2'b11; end
                        3'b100: cntr_alu <= 2'b10;
                        3'b111: lw <= 1'b1;
                        default: ;
                    endcase
                end
                EXEC: begin
                    if (op == 3'b110 || op == 3'b111) begin
                        state    <= MEM;
                        mem_req  <= 1'b1;
                        mem_we   <= (op == 3'b110);
                        mem_addr <= PC_W'(ir[4:0]);
                    end
                end
                MEM: begin
                    if (mem_req && mem_rdy) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (op == 3'b111) begin
                            state  <= WB;
                            reg_we <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (finish) begin
                pc <= fin_pc;
                if (run) begin
                    state    <= FETCH;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= fin_pc;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a tb-side memory answers requests after wait_n
// cycles; each instruction is run from IDLE back to IDLE and its effects checked.
module tb_instr_sequencer;

    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            run;
    logic            mem_req;
    logic            mem_we;
    logic [PC_W-1:0] mem_addr;
    logic            mem_rdy;
    logic [7:0]      mem_rdata;
    logic            alu_zero;
    logic [PC_W-1:0] pc;
    logic [7:0]      ir;
    logic [1:0]      cntr_alu;
    logic            sel_alu_in;
    logic            sel_acc_in;
    logic            lw;
    logic            reg_we;
    logic            acc_we;
    logic            busy;
    logic [2:0]      state_dbg;

    instr_sequencer #(.PC_W(PC_W), .RST_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .alu_zero(alu_zero),
        .pc(pc), .ir(ir), .cntr_alu(cntr_alu), .sel_alu_in(sel_alu_in),
        .sel_acc_in(sel_acc_in), .lw(lw), .reg_we(reg_we), .acc_we(acc_we),
        .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    logic [7:0] mem [256];
    int  vectors = 0;
    int  miscompares = 0;
    bit  auto_mem;
    int  wait_n;
    int  wait_cnt;

    // per-instruction observations
    int          cycles, n_reg, n_acc, n_both, reg_cyc;
    logic        lw_at_we, sel_alu_at_we, sel_acc_at_we, gap, m_seen, m_we;
    logic [7:0]  m_addr, f_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; the memory model answers #1 after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_mem) begin
            if (mem_req) begin
                if (wait_cnt == wait_n) begin
                    mem_rdy   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    wait_cnt  = 0;
                end else begin
                    mem_rdy = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_rdy  = 1'b0;
                wait_cnt = 0;
            end
        end
    endtask

    task automatic sample();
        if (reg_we) begin
            n_reg++; reg_cyc = cycles; lw_at_we = lw; sel_alu_at_we = sel_alu_in;
        end
        if (acc_we) begin
            n_acc++; sel_acc_at_we = sel_acc_in;
        end
        if (reg_we && acc_we) n_both++;
        if (cycles == 1) f_addr = mem_addr;
        if (!mem_req) gap = 1'b1;
        else if (gap && !m_seen) begin
            m_seen = 1'b1; m_addr = mem_addr; m_we = mem_we;
        end
    endtask

    // Run one instruction from IDLE; run drops after cycle drop_at.
    task automatic run_one(input string tag, input int drop_at);
        cycles = 0; n_reg = 0; n_acc = 0; n_both = 0; reg_cyc = 0;
        lw_at_we = 0; sel_alu_at_we = 0; sel_acc_at_we = 0;
        gap = 0; m_seen = 0; m_we = 0; m_addr = 0; f_addr = 0;
        run = 1'b1;
        tick();
        cycles = 1;
        sample();
        if (drop_at <= 1) run = 1'b0;
        while (busy && cycles < 40) begin
            tick();
            if (busy) begin
                cycles++;
                sample();
                if (cycles == drop_at) run = 1'b0;
            end
        end
        run = 1'b0;
        check({tag, "_idle"}, busy, 0);
        check({tag, "_no_double_strobe"}, n_both, 0);
    endtask

    task automatic check_instr(input string tag, input int exp_cyc, input int exp_reg,
                               input int exp_acc, input logic [7:0] exp_pc);
        check({tag, "_cycles"}, cycles, exp_cyc);
        check({tag, "_reg_we_pulses"}, n_reg, exp_reg);
        check({tag, "_acc_we_pulses"}, n_acc, exp_acc);
        check({tag, "_pc"}, pc, exp_pc);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; mem_rdy = 1'b0; mem_rdata = 8'h00; alu_zero = 1'b0;
        auto_mem = 1'b1; wait_n = 0; wait_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // reset state
        tick(); tick();
        rst_n = 1'b1;
        check("rst_state", state_dbg, 0);
        check("rst_pc", pc, 8'h00);
        check("rst_ir", ir, 8'h00);
        check("rst_cntr_alu", cntr_alu, 0);
        check("rst_outputs", {mem_req, mem_we, busy, reg_we, acc_we, sel_alu_in, sel_acc_in, lw}, 0);

        mem[8'h00] = 8'h41; mem[8'h01] = 8'h2A; mem[8'h02] = 8'h60; mem[8'h03] = 8'hA0;
        mem[8'h04] = 8'hC5; mem[8'h05] = 8'hE3; mem[8'h06] = 8'h89;
        mem[8'h10] = 8'h9F; mem[8'h11] = 8'h00; mem[8'h12] = 8'hC7;

        // ALU add, zero wait
        run_one("add", 1);
        check_instr("add", 3, 1, 0, 8'h01);
        check("add_fetch_addr", f_addr, 8'h00);
        check("add_reg_we_cycle", reg_cyc, 3);
        check("add_cntr_alu", cntr_alu, 2'b00);
        check("add_sel_alu_lw", {sel_alu_at_we, lw_at_we}, 2'b10);
        check("add_ir", ir, 8'h41);

        run_one("acc_imm", 1);
        check_instr("acc_imm", 3, 0, 1, 8'h02);
        check("acc_imm_sel", sel_acc_at_we, 1);

        run_one("alu01", 1);
        check_instr("alu01", 3, 1, 0, 8'h03);
        check("alu01_cntr", cntr_alu, 2'b01);

        run_one("alu11", 1);
        check_instr("alu11", 3, 1, 0, 8'h04);
        check("alu11_cntr", cntr_alu, 2'b11);

        run_one("store", 1);
        check_instr("store", 4, 0, 0, 8'h05);
        check("store_mem_addr", m_addr, 8'h05);
        check("store_mem_we", {m_seen, m_we}, 2'b11);

        // load with two wait cycles in both fetch and data phase
        wait_n = 2;
        run_one("load", 1);
        check_instr("load", 9, 1, 0, 8'h06);
        check("load_mem_addr", m_addr, 8'h03);
        check("load_mem_we", {m_seen, m_we}, 2'b10);
        check("load_lw_at_we", lw_at_we, 1);
        check("load_we_cycle", reg_cyc, 9);
        wait_n = 0;

        alu_zero = 1'b1;
        run_one("br_fwd", 1);
        check_instr("br_fwd", 3, 0, 0, 8'h10);
        check("br_fwd_cntr", cntr_alu, 2'b10);

        run_one("br_back_taken", 1);
        check_instr("br_back_taken", 3, 0, 0, 8'h10);

        alu_zero = 1'b0;
        run_one("br_not_taken", 1);
        check_instr("br_not_taken", 3, 0, 0, 8'h11);

        // run drops during EXEC of an accumulator op
        run_one("acc_drop", 3);
        check_instr("acc_drop", 3, 0, 1, 8'h12);
        check("acc_drop_sel", sel_acc_at_we, 0);
        tick(); tick();
        check("acc_drop_quiet", {mem_req, busy, acc_we}, 0);

        // reset while a store is waiting in MEM with mem_rdy arriving
        run = 1'b1;
        tick();
        run = 1'b0;
        tick(); tick(); tick();
        check("st_mem_req", {mem_req, mem_we}, 2'b11);
        check("st_mem_addr", mem_addr, 8'h07);
        rst_n = 1'b0;
        tick();
        check("rst_mid_req", {mem_req, mem_we}, 0);
        check("rst_mid_pc", pc, 8'h00);
        check("rst_mid_state", state_dbg, 0);
        auto_mem = 1'b0;
        mem_rdy = 1'b1;
        rst_n = 1'b1;
        tick();
        check("late_rdy_state", state_dbg, 0);
        check("late_rdy_busy", {busy, mem_req}, 0);
        mem_rdy = 1'b0;
        auto_mem = 1'b1;

        // wrap-around branches
        mem[8'h00] = 8'h90; mem[8'hF1] = 8'h8B; mem[8'hFD] = 8'h85;
        alu_zero = 1'b1;
        run_one("br_neg16", 1);
        check_instr("br_neg16", 3, 0, 0, 8'hF1);
        run_one("br_pos11", 1);
        check_instr("br_pos11", 3, 0, 0, 8'hFD);
        run_one("br_wrap", 1);
        check_instr("br_wrap", 3, 0, 0, 8'h03);
        check("br_wrap_fetch_addr", f_addr, 8'hFD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
